// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin arbiter that shares the single write port of the pclk-side
//   async FIFO between NREQ requesters. A grant covers a whole packet. It is
//   held until the requester marks req_last, or until MAX_BURST words have
//   been pushed. This keeps CONFIG/DATA word pairs of one channel contiguous.
//
// Ports
//   pclk, preset_n   write-side clock, async active-low reset
//   arb_en           1 = new grants allowed; 0 = finish current packet, then hold
//   req_valid        per-requester word available
//   req_last         per-requester: current word ends the packet
//   req_data         requester i word at [i*DW +: DW]
//   req_ready        word of requester i consumed this cycle
//   fifo_write_full  FIFO full, blocks the push the same cycle
//   fifo_write_data  word to FIFO (zero when not pushing)
//   fifo_write_inc   FIFO push strobe
//   grant_id         granted requester index (meaningful while busy)
//   busy             a packet grant is held
//   word_cnt         total words pushed, free-running wrap

module fifo_write_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 34,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned GW        = 2
) (
    input  logic               pclk,
    input  logic               preset_n,
    input  logic               arb_en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_write_full,
    output logic [DW-1:0]      fifo_write_data,
    output logic               fifo_write_inc,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic [15:0]        word_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e        state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] rr_ptr_q;
    logic [7:0]    burst_q;
    logic [15:0]   word_cnt_q;

    logic [DW-1:0] req_word [NREQ];
    logic          pick_found_d;
    logic [GW-1:0] pick_idx_d;
    logic [GW-1:0] cand_d;
    logic          xfer_d;
    logic          pkt_end_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_word[gi]  = req_data[gi*DW +: DW];
            assign req_ready[gi] = busy && (grant_q == GW'(gi)) && !fifo_write_full;
        end
    endgenerate

    // Round-robin search starting at rr_ptr; the first valid requester wins.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        cand_d       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_d = GW'((32'(rr_ptr_q) + k) % NREQ);
            if (!pick_found_d && req_valid[cand_d]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = cand_d;
            end
        end
    end

    assign busy            = (state_q == LOCKED);
    assign xfer_d          = busy && req_valid[grant_q] && !fifo_write_full;
    assign pkt_end_d       = req_last[grant_q] || (burst_q == 8'(MAX_BURST - 1));
    assign fifo_write_inc  = xfer_d;
    assign fifo_write_data = xfer_d ? req_word[grant_q] : '0;
    assign grant_id        = grant_q;
    assign word_cnt        = word_cnt_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            burst_q    <= '0;
            word_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_en && pick_found_d) begin
                        grant_q <= pick_idx_d;
                        burst_q <= '0;
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer_d) begin
                        burst_q    <= burst_q + 8'd1;
                        word_cnt_q <= word_cnt_q + 16'd1;
                        // Serviced requester drops to lowest priority.
                        if (pkt_end_d) begin
                            rr_ptr_q <= (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Directed bench for fifo_write_arbiter (NREQ=4, DW=34, MAX_BURST=8).
//   Simple per-requester word sources feed the arbiter. Pushed words are
//   logged at the falling edge, and the logs are compared with hand-derived
//   sequences.

module tb_fifo_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 34;

    logic               pclk;
    logic               preset_n;
    logic               arb_en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_last;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_write_full;
    logic [DW-1:0]      fifo_write_data;
    logic               fifo_write_inc;
    logic [1:0]         grant_id;
    logic               busy;
    logic [15:0]        word_cnt;

    fifo_write_arbiter #(
        .NREQ      (4),
        .DW        (34),
        .MAX_BURST (8),
        .GW        (2)
    ) dut (
        .pclk            (pclk),
        .preset_n        (preset_n),
        .arb_en          (arb_en),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .fifo_write_full (fifo_write_full),
        .fifo_write_data (fifo_write_data),
        .fifo_write_inc  (fifo_write_inc),
        .grant_id        (grant_id),
        .busy            (busy),
        .word_cnt        (word_cnt)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int rem  [NREQ];
    int len  [NREQ];
    int widx [NREQ];

    logic [DW-1:0] log_d [$];
    logic [1:0]    log_g [$];
    int            log_c [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkw(input int i, input int k);
        return {2'(i), 8'hA0, 8'(i), 16'(k)};
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = (rem[i] > 0);
            req_last[i]  = (len[i] != 0) && ((widx[i] % len[i]) == len[i] - 1);
            req_data[i*DW +: DW] = mkw(i, widx[i]);
        end
    endtask

    // One clock: sample handshakes at the falling edge, advance sources after the rising edge.
    task automatic cycle();
        logic [NREQ-1:0] fire;
        @(negedge pclk);
        fire = req_valid & req_ready;
        if (fifo_write_inc) begin
            log_d.push_back(fifo_write_data);
            log_g.push_back(grant_id);
            log_c.push_back(cyc + 1);
        end
        @(posedge pclk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (fire[i]) begin
                widx[i]++;
                rem[i]--;
            end
        end
        drive();
    endtask

    task automatic reset_dut();
        preset_n        = 1'b0;
        arb_en          = 1'b1;
        fifo_write_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i]  = 0;
            len[i]  = 1;
            widx[i] = 0;
        end
        drive();
        repeat (2) @(posedge pclk);
        #1;
        cyc = 0;
        log_d.delete();
        log_g.delete();
        log_c.delete();
    endtask

    task automatic set_src(input int i, input int r, input int l);
        rem[i]  = r;
        len[i]  = l;
        widx[i] = 0;
    endtask

    initial begin
        preset_n        = 1'b0;
        arb_en          = 1'b0;
        fifo_write_full = 1'b0;
        req_valid       = '0;
        req_last        = '0;
        req_data        = '0;

        // Reset with active inputs: all outputs zero
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_src(i, 2, 1);
        drive();
        #1;
        check("rst_busy",  busy, 0);
        check("rst_inc",   fifo_write_inc, 0);
        check("rst_ready", req_ready, 0);
        check("rst_data",  fifo_write_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_wcnt",  word_cnt, 0);
        cycle();
        check("rst_hold_inc", fifo_write_inc, 0);
        for (int i = 0; i < NREQ; i++) set_src(i, 0, 1);
        drive();
        preset_n = 1'b1;
        repeat (3) cycle();
        check("idle_busy", busy, 0);
        check("idle_wcnt", word_cnt, 0);
        check("idle_pushes", log_d.size(), 0);

        // Round-robin fairness over single-word packets
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_src(i, 2, 1);
        drive();
        preset_n = 1'b1;
        repeat (10) cycle();
        check("rr_count", log_d.size(), 5);
        check("rr_g0", log_g[0], 0);
        check("rr_g1", log_g[1], 1);
        check("rr_g2", log_g[2], 2);
        check("rr_g3", log_g[3], 3);
        check("rr_g4", log_g[4], 0);
        check("rr_d0", log_d[0], mkw(0, 0));
        check("rr_d3", log_d[3], mkw(3, 0));
        check("rr_d4", log_d[4], mkw(0, 1));
        check("rr_c0", log_c[0], 2);
        check("rr_c4", log_c[4], 10);
        check("rr_wcnt", word_cnt, 5);

        // Packet lock: 3-word packet from req0, req1 waiting
        reset_dut();
        set_src(0, 3, 3);
        set_src(1, 2, 2);
        drive();
        preset_n = 1'b1;
        repeat (7) cycle();
        check("lock_count", log_d.size(), 5);
        check("lock_d0", log_d[0], mkw(0, 0));
        check("lock_d1", log_d[1], mkw(0, 1));
        check("lock_d2", log_d[2], mkw(0, 2));
        check("lock_d3", log_d[3], mkw(1, 0));
        check("lock_d4", log_d[4], mkw(1, 1));
        check("lock_c0", log_c[0], 2);
        check("lock_c2", log_c[2], 4);
        check("lock_c3", log_c[3], 6);
        check("lock_wcnt", word_cnt, 5);

        // Backpressure for 3 cycles mid-packet
        reset_dut();
        set_src(0, 5, 5);
        drive();
        preset_n = 1'b1;
        repeat (3) cycle();
        fifo_write_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("full_inc",   fifo_write_inc, 0);
            check("full_ready", req_ready, 0);
            check("full_busy",  busy, 1);
            cycle();
        end
        fifo_write_full = 1'b0;
        #1;
        check("unfull_ready", req_ready, 4'b0001);
        repeat (4) cycle();
        check("bp_count", log_d.size(), 5);
        for (int k = 0; k < 5; k++) check("bp_word", log_d[k], mkw(0, k));
        check("bp_c2", log_c[2], 7);
        check("bp_wcnt", word_cnt, 5);

        // Forced release at MAX_BURST
        reset_dut();
        set_src(2, 10, 0);
        set_src(3, 1, 1);
        drive();
        preset_n = 1'b1;
        repeat (14) cycle();
        check("mb_count", log_d.size(), 11);
        for (int k = 0; k < 8; k++) check("mb_first8", log_d[k], mkw(2, k));
        check("mb_req3", log_d[8], mkw(3, 0));
        check("mb_rest0", log_d[9], mkw(2, 8));
        check("mb_rest1", log_d[10], mkw(2, 9));
        check("mb_wcnt", word_cnt, 11);
        check("mb_hold_busy", busy, 1);
        check("mb_hold_grant", grant_id, 2);

        // arb_en=0 mid-packet: packet finishes, then no new grants
        reset_dut();
        set_src(0, 3, 3);
        set_src(1, 1, 1);
        drive();
        preset_n = 1'b1;
        repeat (2) cycle();
        arb_en = 1'b0;
        repeat (2) cycle();
        check("dis_done", log_d.size(), 3);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("dis_busy", busy, 0);
            check("dis_inc", fifo_write_inc, 0);
        end
        arb_en = 1'b1;
        repeat (2) cycle();
        check("en_count", log_d.size(), 4);
        check("en_word", log_d[3], mkw(1, 0));
        check("en_wcnt", word_cnt, 4);

        // Async reset in the middle of a packet
        reset_dut();
        set_src(0, 4, 4);
        drive();
        preset_n = 1'b1;
        repeat (3) cycle();
        check("ar_pre_inc", fifo_write_inc, 1);
        check("ar_pre_wcnt", word_cnt, 2);
        preset_n = 1'b0;
        #1;
        check("ar_inc",   fifo_write_inc, 0);
        check("ar_busy",  busy, 0);
        check("ar_ready", req_ready, 0);
        check("ar_wcnt",  word_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
